// File: rtl/line_capture_pkg.sv
// Shared definitions for the line capture stage: default geometry and the
// capture FSM state encoding.
package line_capture_pkg;

  localparam int NPIX_DEF = 288;  // pixels per line
  localparam int DW_DEF   = 12;   // ADC sample width
  localparam int AW_DEF   = 9;    // pixel address width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEAD    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_COMMIT  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/line_bank_ram.sv
// Ping-pong line storage: simple dual-port RAM, one write port and one
// registered read port, shaped so it maps onto iCE40 block RAM.
module line_bank_ram
  import line_capture_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW:0]   wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW:0]   rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [2**(AW+1)];

  // Write port.
  // NOTE: neither the array nor its read register is reset -- a reset on
  // either prevents block-RAM inference; the wrapper masks the output instead.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/line_capture.sv
// Captures one line of ADC samples per frame strobe into the write bank of a
// ping-pong buffer and hands completed lines to the host via ready/ack.
module line_capture
  import line_capture_pkg::*;
#(
  parameter int NPIX = NPIX_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int LEAD = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          tick,
  input  logic          otrig,
  input  logic [DW-1:0] adc_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_ready,
  input  logic          frame_ack,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    overrun_cnt
);

  localparam int LW = (LEAD > 0) ? $clog2(LEAD + 1) : 1;

  cap_state_e    state_q, state_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wbank_q, wbank_d;
  logic          frame_ready_q, frame_ready_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]    overrun_cnt_q, overrun_cnt_d;
  logic          wr_en;
  logic          rd_valid_q;
  logic [DW-1:0] ram_rd_data;

  // Next-state logic: capture sequencing plus the commit/drop decision.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    lcnt_d        = lcnt_q;
    waddr_d       = waddr_q;
    wbank_d       = wbank_q;
    frame_ready_d = frame_ready_q;
    frame_cnt_d   = frame_cnt_q;
    overrun_cnt_d = overrun_cnt_q;
    wr_en         = 1'b0;

    // A host ack releases the read bank; COMMIT below may re-raise ready.
    if (frame_ack && frame_ready_q) frame_ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (otrig) begin
          waddr_d = '0;
          if (LEAD > 0) begin
            lcnt_d  = LW'(LEAD);
            state_d = ST_LEAD;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_LEAD: begin
        if (tick) begin
          lcnt_d = lcnt_q - LW'(1);
          if (lcnt_q == LW'(1)) state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (tick) begin
          wr_en   = 1'b1;
          waddr_d = waddr_q + AW'(1);
          if (waddr_q == AW'(NPIX - 1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (!frame_ready_q || frame_ack) begin
          wbank_d       = ~wbank_q;
          frame_ready_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 16'd1;
        end else if (overrun_cnt_q != 8'hFF) begin
          overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; a reset mid-capture abandons the partial line.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      lcnt_q        <= '0;
      waddr_q       <= '0;
      wbank_q       <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      lcnt_q        <= lcnt_d;
      waddr_q       <= waddr_d;
      wbank_q       <= wbank_d;
      frame_ready_q <= frame_ready_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  // Tracks whether the address sampled alongside the RAM read was in range.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_valid_q <= 1'b0;
    else         rd_valid_q <= (int'(rd_addr) < NPIX);
  end

  line_bank_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i ({wbank_q, waddr_q}),
    .wr_data_i (adc_data),
    .rd_addr_i ({~wbank_q, rd_addr}),
    .rd_data_o (ram_rd_data)
  );

  assign rd_data     = rd_valid_q ? ram_rd_data : '0;
  assign frame_ready = frame_ready_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_line_capture.sv
// Randomized self-checking bench for line_capture: a default instance
// (NPIX=288, LEAD=0) and a small one (NPIX=20, AW=5, LEAD=3), both checked
// against a transaction-level line model.
module tb_line_capture;

  localparam int NP0 = 288;
  localparam int NP1 = 20;

  logic        clk = 1'b0;
  logic        resetn;
  logic        tick_s     [2];
  logic        otrig_s    [2];
  logic        ack_s      [2];
  logic [11:0] adc_s      [2];
  logic [8:0]  rd_addr_s  [2];
  logic [11:0] rd_data_s  [2];
  logic        ready_s    [2];
  logic        busy_s     [2];
  logic [15:0] fcnt_s     [2];
  logic [7:0]  ocnt_s     [2];

  int checks = 0;
  int errors = 0;

  // Reference model: the line visible in the read bank plus host-side status.
  int exp_line  [2][NP0];
  bit has_line  [2];
  bit exp_ready [2];
  int exp_fcnt  [2];
  int exp_ocnt  [2];

  always #5 clk = ~clk;

  line_capture #(.NPIX(NP0), .DW(12), .AW(9), .LEAD(0)) dut0 (
    .clk(clk), .resetn(resetn), .tick(tick_s[0]), .otrig(otrig_s[0]),
    .adc_data(adc_s[0]), .rd_addr(rd_addr_s[0]), .rd_data(rd_data_s[0]),
    .frame_ready(ready_s[0]), .frame_ack(ack_s[0]), .busy(busy_s[0]),
    .frame_cnt(fcnt_s[0]), .overrun_cnt(ocnt_s[0])
  );

  line_capture #(.NPIX(NP1), .DW(12), .AW(5), .LEAD(3)) dut1 (
    .clk(clk), .resetn(resetn), .tick(tick_s[1]), .otrig(otrig_s[1]),
    .adc_data(adc_s[1]), .rd_addr(rd_addr_s[1][4:0]), .rd_data(rd_data_s[1]),
    .frame_ready(ready_s[1]), .frame_ack(ack_s[1]), .busy(busy_s[1]),
    .frame_cnt(fcnt_s[1]), .overrun_cnt(ocnt_s[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int npix_of(input int u);
    return (u == 0) ? NP0 : NP1;
  endfunction

  function automatic int lead_of(input int u);
    return (u == 0) ? 0 : 3;
  endfunction

  // One clock of stimulus, applied on the falling edge.
  task automatic cycle(input int u, input bit t, input int d, input bit o, input bit a);
    @(negedge clk);
    tick_s[u]  = t;
    adc_s[u]   = 12'(d);
    otrig_s[u] = o;
    ack_s[u]   = a;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      has_line[u]  = 1'b0;
      exp_ready[u] = 1'b0;
      exp_fcnt[u]  = 0;
      exp_ocnt[u]  = 0;
    end
  endtask

  task automatic check_status(input int u, input string tag);
    check($sformatf("%s ready u%0d", tag, u), 32'(ready_s[u]), 32'(exp_ready[u]));
    check($sformatf("%s fcnt u%0d", tag, u), 32'(fcnt_s[u]), 32'(exp_fcnt[u]));
    check($sformatf("%s ocnt u%0d", tag, u), 32'(ocnt_s[u]), 32'(exp_ocnt[u]));
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("%s busy u%0d", tag, u), 32'(busy_s[u]), 32'd0);
      check($sformatf("%s rd_data u%0d", tag, u), 32'(rd_data_s[u]), 32'd0);
      check_status(u, tag);
    end
  endtask

  // Host releases the read bank with a one-cycle ack.
  task automatic do_ack(input int u);
    cycle(u, 1'b0, 0, 1'b0, 1'b1);
    cycle(u, 1'b0, 0, 1'b0, 1'b0);
    exp_ready[u] = 1'b0;
    check_status(u, "ack");
  endtask

  // One frame: strobe, LEAD skipped ticks, NPIX sampled ticks, commit.
  task automatic run_frame(input int u, input bit ramp, input bit fast,
                           input bit coincide, input bit mid_otrig, input int rst_at);
    int n  = npix_of(u);
    int ld = lead_of(u);
    int capt [NP0];
    int d;
    int gap;
    cycle(u, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < ld + n; i++) begin
      if (i < ld)    d = 'hFFF;
      else if (ramp) d = i - ld;
      else           d = int'($urandom_range(0, 4095));
      cycle(u, 1'b1, d, mid_otrig && (i == ld + 100), 1'b0);
      if (i == 0) check("busy_rise", 32'(busy_s[u]), 32'd1);
      if (i >= ld) capt[i - ld] = d;
      if (rst_at >= 0 && i == ld + rst_at) begin
        #2 resetn = 1'b0;
        model_reset();
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        tick_s[u] = 1'b0;
        resetn    = 1'b1;
        return;
      end
      if (i != ld + n - 1) begin
        gap = fast ? 0 : int'($urandom_range(0, 2));
        repeat (gap) cycle(u, 1'b0, int'($urandom_range(0, 4095)), 1'b0, 1'b0);
      end
    end
    // COMMIT cycle: still busy, ready not yet updated.
    cycle(u, 1'b0, 0, 1'b0, coincide);
    check("busy_commit", 32'(busy_s[u]), 32'd1);
    check("ready_pre", 32'(ready_s[u]), 32'(exp_ready[u]));
    cycle(u, 1'b0, 0, 1'b0, 1'b0);
    if (!exp_ready[u] || coincide) begin
      for (int k = 0; k < n; k++) exp_line[u][k] = capt[k];
      has_line[u]  = 1'b1;
      exp_ready[u] = 1'b1;
      exp_fcnt[u]  = (exp_fcnt[u] + 1) % 65536;
    end else if (exp_ocnt[u] < 255) begin
      exp_ocnt[u]++;
    end
    check("busy_fall", 32'(busy_s[u]), 32'd0);
    check_status(u, "commit");
  endtask

  // Pipelined readback, each result checked one clock after its address.
  task automatic read_line(input int u, input bit full);
    int n    = npix_of(u);
    int amax = (u == 0) ? 512 : 32;
    int addrs[$];
    int prev = -1;
    int exp;
    if (full) for (int a = 0; a < n; a++) addrs.push_back(a);
    else repeat (12) addrs.push_back(int'($urandom_range(0, amax - 1)));
    addrs.push_back(0);
    addrs.push_back(n - 1);
    addrs.push_back(n);
    addrs.push_back(amax - 1);
    for (int k = 0; k <= addrs.size(); k++) begin
      @(negedge clk);
      if (prev >= 0) begin
        exp = (prev < n) ? exp_line[u][prev] : 0;
        check($sformatf("rd u%0d a%0d", u, prev), 32'(rd_data_s[u]), 32'(exp));
      end
      if (k < addrs.size()) begin
        rd_addr_s[u] = 9'(addrs[k]);
        prev = addrs[k];
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    for (int u = 0; u < 2; u++) begin
      tick_s[u] = 1'b0; otrig_s[u] = 1'b0; ack_s[u] = 1'b0;
      adc_s[u] = '0; rd_addr_s[u] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp frame on the default instance, full readback.
    run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    read_line(0, 1'b1);
    do_ack(0);
    read_line(0, 1'b0);

    // Overrun: committed frame, dropped frame, then ack and a fresh frame.
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    read_line(0, 1'b0);
    do_ack(0);
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    read_line(0, 1'b0);

    // Ack coincident with the commit cycle.
    run_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    read_line(0, 1'b1);

    // Stray frame strobe mid-capture.
    do_ack(0);
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    read_line(0, 1'b1);

    // Asynchronous reset at pixel 150, then a clean frame.
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 150);
    repeat (2) @(negedge clk);
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    read_line(0, 1'b1);

    // LEAD=3 instance: skipped ticks carry 0xFFF and must not be stored.
    run_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    read_line(1, 1'b1);

    // Unacked back-to-back frames saturate the overrun counter.
    for (int f = 0; f < 258; f++) run_frame(1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    read_line(1, 1'b1);
    do_ack(1);
    run_frame(1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    read_line(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_capture.md
# line_capture

Downstream stage of the sensor sequencer: captures one line of pixel samples from the parallel video ADC after each `otrig` frame strobe, one sample per 5 MHz pixel `tick`. Stores samples in a ping-pong line buffer and hands completed lines to the host-side controller through a ready/ack handshake and a random-access read port. Frames arriving while the host still holds the previous line are dropped and counted.

## Interface
- `NPIX`, 288: pixels per line (samples per frame).
- `DW`, 12: ADC sample width.
- `AW`, 9: pixel address width; requires 2^AW >= NPIX.
- `LEAD`, 0: ticks skipped after `otrig` before the first sample.

- `clk` in 1: system clock (40 MHz).
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `tick` in 1: pixel-rate flag, one `clk` wide, from the sequencer's fast clock divider.
- `otrig` in 1: one-cycle frame-start strobe from the sequencer FSM.
- `adc_data` in DW: ADC output, valid in any cycle where `tick`=1.
- `rd_addr` in AW: host read address within the ready line.
- `rd_data` out DW: registered read data.
- `frame_ready` out 1: a complete line is held in the read bank.
- `frame_ack` in 1: one-cycle pulse; host releases the read bank.
- `busy` out 1: capture in progress (state != IDLE).
- `frame_cnt` out 16: committed frames, wraps at 65535->0.
- `overrun_cnt` out 8: dropped frames, saturates at 255.

## Operation
- Two banks, `wbank` (written) and `!wbank` (read). One RAM, bank bit is address MSB.
- FSM states: IDLE, LEAD, CAPTURE, COMMIT.
  - IDLE: `otrig`=1 -> LEAD if `LEAD`>0 (load `lcnt`=LEAD), else CAPTURE; `waddr`=0.
  - LEAD: on `tick`, `lcnt`--; the tick that takes `lcnt` to 0 -> CAPTURE. That tick is not sampled.
  - CAPTURE: on each `tick`, write `adc_data` to [`wbank`,`waddr`], `waddr`++. After the write with `waddr`=NPIX-1 -> COMMIT.
  - COMMIT (one cycle): if `frame_ready`=0, or `frame_ack`=1 this cycle, toggle `wbank`, set `frame_ready`=1, `frame_cnt`++. Otherwise drop the line: `wbank` unchanged (overwritten next frame), `overrun_cnt`++ (saturating). Then -> IDLE.
- `otrig` outside IDLE: ignored, no effect on the current capture.
- `frame_ack` with `frame_ready`=1, outside COMMIT: `frame_ready`->0 next cycle.
- `frame_ack` with `frame_ready`=0: ignored.
- Simultaneous `frame_ack` and COMMIT: the ack is applied first, the commit succeeds, and `frame_ready` stays 1 (new line).
- Read port: `rd_data` <= RAM[`!wbank`,`rd_addr`]. Reads are valid regardless of `frame_ready`. Data is only defined for `rd_addr` < NPIX; for `rd_addr` >= NPIX, `rd_data` = 0.
- Reset mid-capture: FSM->IDLE, partial line discarded, no `frame_ready`.

## Timing
- Reset values: `rd_data`=0, `frame_ready`=0, `busy`=0, `frame_cnt`=0, `overrun_cnt`=0, `wbank`=0, state IDLE. RAM contents undefined.
- `busy` rises the cycle after `otrig`. It falls the cycle after COMMIT.
- `frame_ready` rises the cycle after COMMIT, i.e. 2 clk after the final sampling tick.
- Read latency: 1 clk from `rd_addr` to `rd_data`.
- Line duration: (LEAD+NPIX) ticks. At 5 MHz with defaults this is 57.6 us, shorter than the sequencer's minimum frame period, so back-to-back `otrig` strobes never overlap a capture.

## Structure
- Shared package holds: `NPIX`/`DW`/`AW` defaults and the FSM state encoding (2-bit: IDLE=0, LEAD=1, CAPTURE=2, COMMIT=3).
- Sub-module `line_bank_ram`:
  - simple dual-port, 2^(AW+1) x DW;
  - one write port, one registered read port;
  - infers iCE40 EBR.
- The RAM's output reset and the out-of-range zeroing live in the wrapper.

## Test plan
- Single frame, defaults: `adc_data` = pixel index on each tick, `otrig` then 288 ticks -> `frame_ready`=1 two clk after the last tick; reading addrs 0..287 returns 0..287 (1-clk latency); `frame_cnt`=1.
- LEAD=3: `otrig`, then `adc_data`=0xFFF for 3 ticks, then ramp -> addr 0 holds the value at the 4th tick; no 0xFFF in the buffer.
- Overrun: two frames, no ack -> `frame_cnt`=1, `overrun_cnt`=1, read bank still holds frame 1; after ack plus a third frame, the buffer holds frame 3 data.
- Ack coincident with COMMIT cycle -> `frame_ready` stays 1, `frame_cnt` increments, no overrun.
- `otrig` pulsed at pixel 100 of an active capture -> ignored; the line completes at 288 samples with correct data.
- Async reset asserted at pixel 150 -> all outputs at reset values immediately; the next `otrig` produces a clean frame with `frame_cnt`=1. Also: 256 unacked frames -> `overrun_cnt` saturates at 255.
